// File: rtl/output_driver_sequencer.sv
// Output driver command sequencer.
// Turns one accepted request into the ordered command burst on the shared
// 32-bit driver command bus: SET_DELAY, SET_WIDTH, optional SET_PATTERN
// words (fetched from the pattern source), then SET_MODE. After SET_MODE the
// block stays busy for SETTLE_CYCLES so the mode toggle can cross into the
// EVR domain before another request can be taken.
//
// Timing model: the state register holds the "current command"; every bus
// output is registered from it, so a command's strobe appears one cycle after
// its state is entered. The pattern address is the exception: it is the live
// word counter, so it is already presented while PAT_FETCH is the current
// state and the 1-cycle-latency pattern data is ready at the PAT_WRITE edge.
module output_driver_sequencer #(
    parameter int NUM_CHANNELS          = 8,
    parameter int CHANNEL_WIDTH         = 3,
    parameter int SERDES_WIDTH          = 4,
    parameter int PATTERN_ADDRESS_WIDTH = 13,
    parameter int SETTLE_CYCLES         = 8
) (
    input  logic                             sysClk,
    input  logic                             sysReset_n,
    input  logic                             reqValid,
    output logic                             reqReady,
    input  logic [CHANNEL_WIDTH-1:0]         reqChannel,
    input  logic [1:0]                       reqMode,
    input  logic [25:0]                      reqDelayInfo,
    input  logic [23:0]                      reqWidthInfo,
    input  logic [PATTERN_ADDRESS_WIDTH-1:0] reqPatternLast,
    output logic [PATTERN_ADDRESS_WIDTH-1:0] patAddr,
    input  logic [SERDES_WIDTH-1:0]          patData,
    output logic [NUM_CHANNELS-1:0]          csrStrobe,
    output logic [31:0]                      gpioOut,
    output logic                             busy,
    output logic                             done,
    output logic                             badChannel
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [31:0] NUM_CH_U = 32'(NUM_CHANNELS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_WIDTH,
        ST_PAT_FETCH,
        ST_PAT_WRITE,
        ST_MODE,
        ST_SETTLE
    } state_t;

    // Sequencing state and captured request
    state_t                             state_q, state_d;
    logic [1:0]                         mode_q, mode_d;
    logic [CHANNEL_WIDTH-1:0]           chan_q, chan_d;
    logic [25:0]                        delay_q, delay_d;
    logic [23:0]                        width_q, width_d;
    logic [PATTERN_ADDRESS_WIDTH-1:0]   last_q, last_d;
    logic [PATTERN_ADDRESS_WIDTH-1:0]   pat_addr_q, pat_addr_d;
    logic [SETTLE_W-1:0]                settle_q, settle_d;

    // Registered outputs
    logic                               req_ready_q, req_ready_d;
    logic                               busy_q, busy_d;
    logic [NUM_CHANNELS-1:0]            strobe_q, strobe_d;
    logic [31:0]                        gpio_q, gpio_d;
    logic                               done_q, done_d;
    logic                               bad_q, bad_d;

    logic                               accept;
    logic [31:0]                        chan_wide;
    logic                               channel_ok;
    logic [NUM_CHANNELS-1:0]            chan_onehot;
    logic [31:0]                        cmd_word;
    logic                               cmd_strobe;

    assign accept     = reqValid & req_ready_q;
    assign chan_wide  = 32'(chan_q);
    assign channel_ok = (chan_wide < NUM_CH_U);

    // One-hot strobe pattern for the captured channel; out-of-range gives all zero
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_onehot
        assign chan_onehot[gi] = (chan_wide == 32'(gi));
    end

    // State register plus captured request fields
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            chan_q     <= '0;
            delay_q    <= '0;
            width_q    <= '0;
            last_q     <= '0;
            pat_addr_q <= '0;
            settle_q   <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            chan_q     <= chan_d;
            delay_q    <= delay_d;
            width_q    <= width_d;
            last_q     <= last_d;
            pat_addr_q <= pat_addr_d;
            settle_q   <= settle_d;
        end
    end

    // Next-state logic: walks the command burst and the settle countdown
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        chan_d     = chan_q;
        delay_d    = delay_q;
        width_d    = width_q;
        last_d     = last_q;
        pat_addr_d = pat_addr_q;
        settle_d   = settle_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_DELAY;
                    mode_d     = reqMode;
                    chan_d     = reqChannel;
                    delay_d    = reqDelayInfo;
                    width_d    = reqWidthInfo;
                    last_d     = reqPatternLast;
                    pat_addr_d = '0;
                end
            end
            ST_DELAY: state_d = ST_WIDTH;
            ST_WIDTH: state_d = mode_q[1] ? ST_PAT_FETCH : ST_MODE;
            ST_PAT_FETCH: state_d = ST_PAT_WRITE;
            ST_PAT_WRITE: begin
                // Stop on the last word rather than wrapping, so an all-ones
                // last address covers the whole pattern RAM exactly once.
                if (pat_addr_q == last_q) begin
                    state_d = ST_MODE;
                end else begin
                    state_d    = ST_PAT_FETCH;
                    pat_addr_d = pat_addr_q + PATTERN_ADDRESS_WIDTH'(1);
                end
            end
            ST_MODE: begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: command word for the current state, handshake and pulses
    always_comb begin
        cmd_word   = '0;
        cmd_strobe = 1'b0;
        case (state_q)
            ST_DELAY: begin
                cmd_word   = {2'b01, 4'b0000, delay_q};
                cmd_strobe = 1'b1;
            end
            ST_WIDTH: begin
                cmd_word   = {2'b10, 6'b000000, width_q};
                cmd_strobe = 1'b1;
            end
            ST_PAT_WRITE: begin
                cmd_word[31:30]                        = 2'b11;
                cmd_word[10 +: PATTERN_ADDRESS_WIDTH]  = pat_addr_q;
                cmd_word[0 +: SERDES_WIDTH]            = patData;
                cmd_strobe                             = 1'b1;
            end
            ST_MODE: begin
                cmd_word   = {30'd0, mode_q};
                cmd_strobe = 1'b1;
            end
            default: begin
                cmd_word   = '0;
                cmd_strobe = 1'b0;
            end
        endcase
        // A bad channel runs the same timing but never drives the bus.
        strobe_d = (cmd_strobe && channel_ok) ? chan_onehot : '0;
        gpio_d   = (cmd_strobe && channel_ok) ? cmd_word : 32'd0;
        done_d   = (state_q == ST_SETTLE) && (settle_q == SETTLE_LAST);
        bad_d    = done_d && !channel_ok;
        // Ready drops in the cycle right after an accept so a held reqValid
        // is never taken twice, and rises one cycle after the done pulse.
        req_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
        busy_d      = ~req_ready_d;
    end

    // Output registers
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            strobe_q    <= '0;
            gpio_q      <= '0;
            done_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            strobe_q    <= strobe_d;
            gpio_q      <= gpio_d;
            done_q      <= done_d;
            bad_q       <= bad_d;
        end
    end

    assign reqReady   = req_ready_q;
    assign busy       = busy_q;
    assign csrStrobe  = strobe_q;
    assign gpioOut    = gpio_q;
    assign done       = done_q;
    assign badChannel = bad_q;
    assign patAddr    = pat_addr_q;

endmodule

// File: tb/tb_output_driver_sequencer.sv
// Directed testbench for output_driver_sequencer.
// Convention: "cycle k" is sampled 1 time unit after the k-th rising edge
// following the accepting edge E.
module tb_output_driver_sequencer;

    logic        sysClk = 1'b0;
    logic        sysReset_n = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [3:0]  reqChannel = '0;
    logic [1:0]  reqMode = '0;
    logic [25:0] reqDelayInfo = '0;
    logic [23:0] reqWidthInfo = '0;
    logic [12:0] reqPatternLast = '0;
    logic [12:0] patAddr;
    logic [3:0]  patData;
    logic [7:0]  csrStrobe;
    logic [31:0] gpioOut;
    logic        busy;
    logic        done;
    logic        badChannel;

    logic [3:0]  pat_mem [0:8191];
    int          total_cnt = 0;
    int          bad_cnt = 0;

    output_driver_sequencer #(
        .NUM_CHANNELS(8),
        .CHANNEL_WIDTH(4),
        .SERDES_WIDTH(4),
        .PATTERN_ADDRESS_WIDTH(13),
        .SETTLE_CYCLES(8)
    ) dut (
        .sysClk(sysClk),
        .sysReset_n(sysReset_n),
        .reqValid(reqValid),
        .reqReady(reqReady),
        .reqChannel(reqChannel),
        .reqMode(reqMode),
        .reqDelayInfo(reqDelayInfo),
        .reqWidthInfo(reqWidthInfo),
        .reqPatternLast(reqPatternLast),
        .patAddr(patAddr),
        .patData(patData),
        .csrStrobe(csrStrobe),
        .gpioOut(gpioOut),
        .busy(busy),
        .done(done),
        .badChannel(badChannel)
    );

    always #5 sysClk = ~sysClk;

    // Pattern source with one cycle of read latency
    always @(posedge sysClk) patData <= pat_mem[patAddr];

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    // Waits (bounded) for ready, presents a request, returns 1 unit after edge E
    task automatic issue_req(input logic [3:0] ch, input logic [1:0] mode,
                             input logic [25:0] dly, input logic [23:0] wid,
                             input logic [12:0] last);
        int n;
        n = 0;
        while (reqReady !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total_cnt++;
        if (reqReady !== 1'b1) begin
            bad_cnt++;
            $display("FAIL accept_wait: reqReady=%b required 1", reqReady);
        end
        reqValid       = 1'b1;
        reqChannel     = ch;
        reqMode        = mode;
        reqDelayInfo   = dly;
        reqWidthInfo   = wid;
        reqPatternLast = last;
        tick();
        // Fields changing after acceptance must have no effect
        reqValid       = 1'b0;
        reqChannel     = ~ch;
        reqMode        = ~mode;
        reqDelayInfo   = ~dly;
        reqWidthInfo   = ~wid;
        reqPatternLast = ~last;
    endtask

    task automatic test_reset();
        #1 sysReset_n = 1'b0;
        #1;
        total_cnt++; if (csrStrobe !== 8'h00) begin bad_cnt++; $display("FAIL rst_strobe: got %h want 00", csrStrobe); end
        total_cnt++; if (gpioOut !== 32'h0) begin bad_cnt++; $display("FAIL rst_gpio: got %h want 0", gpioOut); end
        total_cnt++; if (patAddr !== 13'h0) begin bad_cnt++; $display("FAIL rst_patAddr: got %h want 0", patAddr); end
        total_cnt++; if (done !== 1'b0) begin bad_cnt++; $display("FAIL rst_done: got %b want 0", done); end
        total_cnt++; if (badChannel !== 1'b0) begin bad_cnt++; $display("FAIL rst_bad: got %b want 0", badChannel); end
        total_cnt++; if (reqReady !== 1'b1) begin bad_cnt++; $display("FAIL rst_ready: got %b want 1", reqReady); end
        total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
        repeat (2) @(posedge sysClk);
        #3 sysReset_n = 1'b1;
        tick();
        total_cnt++; if (reqReady !== 1'b1) begin bad_cnt++; $display("FAIL rst_ready_after: got %b want 1", reqReady); end
        total_cnt++; if (csrStrobe !== 8'h00) begin bad_cnt++; $display("FAIL rst_strobe_after: got %h want 00", csrStrobe); end
        $display("test_reset: checks so far=%0d", total_cnt);
    endtask

    // Pulse mode, ch 2: DELAY/WIDTH/MODE at k=1..3, done k=11, ready k=12
    task automatic test_pulse(input string tag);
        logic [7:0]  exp_s;
        logic [31:0] exp_g;
        issue_req(4'd2, 2'd1, 26'h0000123, 24'h000045, 13'd0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_s = (k <= 3) ? 8'h04 : 8'h00;
            case (k)
                1: exp_g = 32'h40000123;
                2: exp_g = 32'h80000045;
                3: exp_g = 32'h00000001;
                default: exp_g = 32'h0;
            endcase
            total_cnt++; if (csrStrobe !== exp_s) begin bad_cnt++; $display("FAIL %s_strobe k=%0d: got %h want %h", tag, k, csrStrobe, exp_s); end
            total_cnt++; if (gpioOut !== exp_g) begin bad_cnt++; $display("FAIL %s_gpio k=%0d: got %h want %h", tag, k, gpioOut, exp_g); end
            total_cnt++; if (done !== (k == 11)) begin bad_cnt++; $display("FAIL %s_done k=%0d: got %b want %b", tag, k, done, (k == 11)); end
            total_cnt++; if (badChannel !== 1'b0) begin bad_cnt++; $display("FAIL %s_bad k=%0d: got %b want 0", tag, k, badChannel); end
            total_cnt++; if (reqReady !== (k == 12)) begin bad_cnt++; $display("FAIL %s_ready k=%0d: got %b want %b", tag, k, reqReady, (k == 12)); end
            total_cnt++; if (busy !== (k != 12)) begin bad_cnt++; $display("FAIL %s_busy k=%0d: got %b want %b", tag, k, busy, (k != 12)); end
        end
        $display("test_pulse(%s): checks so far=%0d", tag, total_cnt);
    endtask

    // Pattern single, ch 0, 4 words 1,2,4,8
    task automatic test_pattern();
        logic [7:0]  exp_s;
        logic [31:0] exp_g;
        pat_mem[0] = 4'h1; pat_mem[1] = 4'h2; pat_mem[2] = 4'h4; pat_mem[3] = 4'h8;
        issue_req(4'd0, 2'd2, 26'h0000010, 24'h000020, 13'd3);
        for (int k = 1; k <= 20; k++) begin
            tick();
            case (k)
                1:  exp_g = 32'h40000010;
                2:  exp_g = 32'h80000020;
                4:  exp_g = 32'hC0000001;
                6:  exp_g = 32'hC0000402;
                8:  exp_g = 32'hC0000804;
                10: exp_g = 32'hC0000C08;
                11: exp_g = 32'h00000002;
                default: exp_g = 32'h0;
            endcase
            exp_s = (k == 1 || k == 2 || k == 4 || k == 6 || k == 8 || k == 10 || k == 11) ? 8'h01 : 8'h00;
            total_cnt++; if (csrStrobe !== exp_s) begin bad_cnt++; $display("FAIL pat_strobe k=%0d: got %h want %h", k, csrStrobe, exp_s); end
            total_cnt++; if (gpioOut !== exp_g) begin bad_cnt++; $display("FAIL pat_gpio k=%0d: got %h want %h", k, gpioOut, exp_g); end
            total_cnt++; if (done !== (k == 19)) begin bad_cnt++; $display("FAIL pat_done k=%0d: got %b want %b", k, done, (k == 19)); end
            total_cnt++; if (reqReady !== (k == 20)) begin bad_cnt++; $display("FAIL pat_ready k=%0d: got %b want %b", k, reqReady, (k == 20)); end
            if (k == 3 || k == 5 || k == 7 || k == 9) begin
                total_cnt++;
                if (patAddr !== 13'((k - 3) / 2)) begin
                    bad_cnt++;
                    $display("FAIL pat_addr k=%0d: got %h want %h", k, patAddr, 13'((k - 3) / 2));
                end
            end
        end
        $display("test_pattern: checks so far=%0d", total_cnt);
    endtask

    // Out-of-range channel: silent bus, done and badChannel together at k=11
    task automatic test_bad_channel();
        issue_req(4'd9, 2'd1, 26'h0000123, 24'h000045, 13'd0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            total_cnt++; if (csrStrobe !== 8'h00) begin bad_cnt++; $display("FAIL badch_strobe k=%0d: got %h want 00", k, csrStrobe); end
            total_cnt++; if (gpioOut !== 32'h0) begin bad_cnt++; $display("FAIL badch_gpio k=%0d: got %h want 0", k, gpioOut); end
            total_cnt++; if (done !== (k == 11)) begin bad_cnt++; $display("FAIL badch_done k=%0d: got %b want %b", k, done, (k == 11)); end
            total_cnt++; if (badChannel !== (k == 11)) begin bad_cnt++; $display("FAIL badch_flag k=%0d: got %b want %b", k, badChannel, (k == 11)); end
            total_cnt++; if (reqReady !== (k == 12)) begin bad_cnt++; $display("FAIL badch_ready k=%0d: got %b want %b", k, reqReady, (k == 12)); end
        end
        $display("test_bad_channel: checks so far=%0d", total_cnt);
    endtask

    // Second request held valid during busy: accepted at k=13, strobes k=14..16
    task automatic test_back_to_back();
        logic [7:0]  exp_s;
        logic [31:0] exp_g;
        logic        exp_r;
        issue_req(4'd5, 2'd0, 26'h0000777, 24'h000888, 13'd0);
        reqValid     = 1'b1;
        reqChannel   = 4'd3;
        reqMode      = 2'd1;
        reqDelayInfo = 26'h3FFFFFF;
        reqWidthInfo = 24'hFFFFFF;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 13) begin
                reqValid   = 1'b0;
                reqChannel = 4'd6;
                reqMode    = 2'd2;
            end
            case (k)
                1:  exp_g = 32'h40000777;
                2:  exp_g = 32'h80000888;
                14: exp_g = 32'h43FFFFFF;
                15: exp_g = 32'h80FFFFFF;
                16: exp_g = 32'h00000001;
                default: exp_g = 32'h0;
            endcase
            exp_s = (k <= 3) ? 8'h20 : ((k >= 14 && k <= 16) ? 8'h08 : 8'h00);
            exp_r = (k == 12 || k == 25);
            total_cnt++; if (csrStrobe !== exp_s) begin bad_cnt++; $display("FAIL b2b_strobe k=%0d: got %h want %h", k, csrStrobe, exp_s); end
            total_cnt++; if (gpioOut !== exp_g) begin bad_cnt++; $display("FAIL b2b_gpio k=%0d: got %h want %h", k, gpioOut, exp_g); end
            total_cnt++; if (done !== (k == 11 || k == 24)) begin bad_cnt++; $display("FAIL b2b_done k=%0d: got %b want %b", k, done, (k == 11 || k == 24)); end
            if (k != 13) begin
                total_cnt++; if (reqReady !== exp_r) begin bad_cnt++; $display("FAIL b2b_ready k=%0d: got %b want %b", k, reqReady, exp_r); end
            end
        end
        $display("test_back_to_back: checks so far=%0d", total_cnt);
    endtask

    // Reset asserted during the PAT_WRITE of word 2, then a clean pulse request
    task automatic test_reset_mid();
        pat_mem[0] = 4'h3; pat_mem[1] = 4'h5; pat_mem[2] = 4'h6;
        pat_mem[3] = 4'h9; pat_mem[4] = 4'hA; pat_mem[5] = 4'hC;
        issue_req(4'd1, 2'd3, 26'h0000001, 24'h000002, 13'd5);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) begin
                total_cnt++; if (csrStrobe !== 8'h02) begin bad_cnt++; $display("FAIL mid_strobe_w1: got %h want 02", csrStrobe); end
                total_cnt++; if (gpioOut !== 32'hC0000405) begin bad_cnt++; $display("FAIL mid_gpio_w1: got %h want C0000405", gpioOut); end
            end
        end
        total_cnt++; if (patAddr !== 13'd2) begin bad_cnt++; $display("FAIL mid_addr_w2: got %h want 0002", patAddr); end
        total_cnt++; if (reqReady !== 1'b0) begin bad_cnt++; $display("FAIL mid_ready_busy: got %b want 0", reqReady); end
        #2 sysReset_n = 1'b0;
        #1;
        total_cnt++; if (csrStrobe !== 8'h00) begin bad_cnt++; $display("FAIL mid_rst_strobe: got %h want 00", csrStrobe); end
        total_cnt++; if (gpioOut !== 32'h0) begin bad_cnt++; $display("FAIL mid_rst_gpio: got %h want 0", gpioOut); end
        total_cnt++; if (patAddr !== 13'h0) begin bad_cnt++; $display("FAIL mid_rst_addr: got %h want 0", patAddr); end
        total_cnt++; if (done !== 1'b0 || badChannel !== 1'b0) begin bad_cnt++; $display("FAIL mid_rst_pulses: got done=%b bad=%b want 0 0", done, badChannel); end
        total_cnt++; if (reqReady !== 1'b1) begin bad_cnt++; $display("FAIL mid_rst_ready: got %b want 1", reqReady); end
        repeat (2) @(posedge sysClk);
        #3 sysReset_n = 1'b1;
        tick();
        total_cnt++; if (reqReady !== 1'b1) begin bad_cnt++; $display("FAIL mid_ready_release: got %b want 1", reqReady); end
        total_cnt++; if (csrStrobe !== 8'h00) begin bad_cnt++; $display("FAIL mid_strobe_release: got %h want 00", csrStrobe); end
        $display("test_reset_mid: checks so far=%0d", total_cnt);
        test_pulse("after_rst");
    endtask

    // Full pattern RAM: 8192 words, ch 7, pattern loop
    task automatic test_full_ram();
        logic [7:0]  exp_s;
        logic [31:0] exp_g;
        int          stream_err;
        int          first_err_k;
        int          pat_strobes;
        int          j;
        for (int i = 0; i < 8192; i++) pat_mem[i] = 4'(i);
        stream_err  = 0;
        first_err_k = -1;
        pat_strobes = 0;
        issue_req(4'd7, 2'd3, 26'h2AAAAAA, 24'h555555, 13'h1FFF);
        for (int k = 1; k <= 16396; k++) begin
            tick();
            exp_s = 8'h00;
            exp_g = 32'h0;
            if (k == 1) begin
                exp_s = 8'h80; exp_g = 32'h42AAAAAA;
            end else if (k == 2) begin
                exp_s = 8'h80; exp_g = 32'h80555555;
            end else if (k == 16387) begin
                exp_s = 8'h80; exp_g = 32'h00000003;
            end else if (k >= 4 && k <= 16386 && (k % 2) == 0) begin
                j = (k - 4) / 2;
                exp_s = 8'h80;
                exp_g = 32'hC0000000 | (32'(j) << 10) | 32'(j % 16);
            end
            if (csrStrobe === 8'h80 && gpioOut[31:30] === 2'b11) pat_strobes++;
            if (csrStrobe !== exp_s || gpioOut !== exp_g || done !== (k == 16395)
                || reqReady !== (k == 16396)) begin
                stream_err++;
                if (first_err_k < 0) first_err_k = k;
            end
            if (k == 16386) begin
                total_cnt++; if (gpioOut !== 32'hC07FFC0F) begin bad_cnt++; $display("FAIL full_last_word: got %h want C07FFC0F", gpioOut); end
                total_cnt++; if (patAddr !== 13'h1FFF) begin bad_cnt++; $display("FAIL full_last_addr: got %h want 1FFF", patAddr); end
            end
            if (k == 16387) begin
                total_cnt++; if (csrStrobe !== 8'h80 || gpioOut !== 32'h00000003) begin bad_cnt++; $display("FAIL full_mode: got strobe=%h word=%h want 80 00000003", csrStrobe, gpioOut); end
            end
            if (k == 16390) begin
                total_cnt++; if (patAddr !== 13'h1FFF) begin bad_cnt++; $display("FAIL full_no_wrap: got %h want 1FFF", patAddr); end
            end
            if (k == 16395) begin
                total_cnt++; if (done !== 1'b1) begin bad_cnt++; $display("FAIL full_done: got %b want 1", done); end
            end
        end
        total_cnt++; if (pat_strobes != 8192) begin bad_cnt++; $display("FAIL full_pat_count: got %0d want 8192", pat_strobes); end
        total_cnt++; if (stream_err != 0) begin bad_cnt++; $display("FAIL full_stream: got %0d bad cycles (first k=%0d) want 0", stream_err, first_err_k); end
        $display("test_full_ram: checks so far=%0d", total_cnt);
    endtask

    initial begin
        test_reset();
        test_pulse("pulse");
        test_pattern();
        test_bad_channel();
        test_back_to_back();
        test_reset_mid();
        test_full_ram();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
